// File: rtl/pmp_phase_sched.sv
// pmp_phase_sched: merges three wrapped-phase AXI-Stream sources (high, mid, low
// fringe frequency) onto one master stream. Packets go out in the fixed order
// s0 -> s1 -> s2, one whole packet per source, through a single output register
// slice that sustains one beat per cycle.
// Optional packet length enforcement is built when PMP_SCHED_LEN_CHECK_EN is defined.
module pmp_phase_sched #(
    parameter int PHASE_NUM  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int PKT_LEN    = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [PHASE_NUM*DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                            s0_axis_tvalid,
    output logic                            s0_axis_tready,
    input  logic                            s0_axis_tlast,
    input  logic [PHASE_NUM*DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                            s1_axis_tvalid,
    output logic                            s1_axis_tready,
    input  logic                            s1_axis_tlast,
    input  logic [PHASE_NUM*DATA_WIDTH-1:0] s2_axis_tdata,
    input  logic                            s2_axis_tvalid,
    output logic                            s2_axis_tready,
    input  logic                            s2_axis_tlast,
    output logic [PHASE_NUM*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [1:0]                      cur_freq,
    output logic                            set_done,
    output logic [CNT_WIDTH-1:0]            set_cnt,
    output logic                            err_short,
    output logic                            err_long,
    input  logic                            err_clr
);
    localparam int W = PHASE_NUM * DATA_WIDTH;

    typedef enum logic [1:0] {
        F0 = 2'd0,
        F1 = 2'd1,
`ifdef PMP_SCHED_LEN_CHECK_EN
        F2 = 2'd2,
        DRAIN = 2'd3
`else
        F2 = 2'd2
`endif
    } state_t;

    // Grant rotation high -> mid -> low -> high.
    function automatic state_t next_f(input logic [1:0] ch);
        case (ch)
            2'd0:    next_f = F1;
            2'd1:    next_f = F2;
            default: next_f = F0;
        endcase
    endfunction

    logic [W-1:0] s_tdata [3];
    logic [2:0]   s_tvalid, s_tlast, s_tready;

    assign s_tdata[0] = s0_axis_tdata;
    assign s_tdata[1] = s1_axis_tdata;
    assign s_tdata[2] = s2_axis_tdata;
    assign s_tvalid   = {s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    assign s_tlast    = {s2_axis_tlast, s1_axis_tlast, s0_axis_tlast};
    assign s0_axis_tready = s_tready[0];
    assign s1_axis_tready = s_tready[1];
    assign s2_axis_tready = s_tready[2];

    state_t                state_q, state_d;
    logic                  ready_en_q;   // keeps every tready low until the first edge after reset
    logic [W-1:0]          m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  m_set_end_q, m_set_end_d;  // held beat came from the low-frequency channel
    logic [CNT_WIDTH-1:0]  set_cnt_q, set_cnt_d;
    logic [1:0]            ch_sel;
    logic                  slice_ready, fire, fwd, out_last, set_done_w;

`ifdef PMP_SCHED_LEN_CHECK_EN
    localparam int BW = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [1:0]    drain_ch_q, drain_ch_d;
    logic          err_short_q, err_short_d;
    logic          err_long_q, err_long_d;
`endif

    assign set_done_w = m_tvalid_q && m_axis_tready && m_tlast_q && m_set_end_q;

    // Grant, acceptance, packet closing and output slice next-state logic.
    always_comb begin
        state_d     = state_q;
        s_tready    = '0;
        fire        = 1'b0;
        fwd         = 1'b0;
        out_last    = 1'b0;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        m_set_end_d = m_set_end_q;
        set_cnt_d   = set_cnt_q;
        ch_sel      = state_q;
        slice_ready = !m_tvalid_q || m_axis_tready;
`ifdef PMP_SCHED_LEN_CHECK_EN
        beat_cnt_d  = beat_cnt_q;
        drain_ch_d  = drain_ch_q;
        err_short_d = err_clr ? 1'b0 : err_short_q;
        err_long_d  = err_clr ? 1'b0 : err_long_q;
        if (state_q == DRAIN) begin
            // Surplus beats are dropped, so the output slice does not gate them.
            ch_sel           = drain_ch_q;
            s_tready[ch_sel] = ready_en_q;
        end else begin
            s_tready[ch_sel] = ready_en_q && slice_ready;
        end
`else
        s_tready[ch_sel] = ready_en_q && slice_ready;
`endif
        fire = s_tready[ch_sel] && s_tvalid[ch_sel];

        if (fire) begin
`ifdef PMP_SCHED_LEN_CHECK_EN
            if (state_q == DRAIN) begin
                if (s_tlast[ch_sel]) state_d = next_f(ch_sel);
            end else begin
                fwd = 1'b1;
                if (beat_cnt_q == BW'(PKT_LEN - 1)) begin
                    out_last   = 1'b1;
                    beat_cnt_d = '0;
                    if (s_tlast[ch_sel]) begin
                        state_d = next_f(ch_sel);
                    end else begin
                        err_long_d = 1'b1;
                        drain_ch_d = ch_sel;
                        state_d    = DRAIN;
                    end
                end else if (s_tlast[ch_sel]) begin
                    out_last    = 1'b1;
                    err_short_d = 1'b1;
                    beat_cnt_d  = '0;
                    state_d     = next_f(ch_sel);
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
`else
            fwd      = 1'b1;
            out_last = s_tlast[ch_sel];
            if (s_tlast[ch_sel]) state_d = next_f(ch_sel);
`endif
        end

        if (slice_ready) begin
            m_tvalid_d = fwd;
            if (fwd) begin
                m_tdata_d   = s_tdata[ch_sel];
                m_tlast_d   = out_last;
                m_set_end_d = (ch_sel == 2'd2);
            end
        end

        if (set_done_w) set_cnt_d = set_cnt_q + 1'b1;
    end

    // State, output slice and set counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= F0;
            ready_en_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_set_end_q <= 1'b0;
            set_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= 1'b1;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_set_end_q <= m_set_end_d;
            set_cnt_q   <= set_cnt_d;
        end
    end

`ifdef PMP_SCHED_LEN_CHECK_EN
    // Beat counter, drain channel and sticky length error registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_q  <= '0;
            drain_ch_q  <= 2'd0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            drain_ch_q  <= drain_ch_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign err_short = err_short_q;
    assign err_long  = err_long_q;
`else
    assign err_short = 1'b0;
    assign err_long  = 1'b0;
`endif

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign cur_freq      = state_q;
    assign set_done      = set_done_w;
    assign set_cnt       = set_cnt_q;

endmodule

// File: tb/tb_pmp_phase_sched.sv
// Testbench for pmp_phase_sched. The reference model is a queue of expected
// output beats built from whole packets in high -> mid -> low order; every
// accepted output beat is popped and compared. Length-check scenarios are
// compiled in when PMP_SCHED_LEN_CHECK_EN is defined.
module tb_pmp_phase_sched;
    localparam int PKT_LEN = 256;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [127:0] s_data [3];
    logic [2:0]   s_valid = '0;
    logic [2:0]   s_last = '0;
    wire  [2:0]   s_ready;
    wire  [127:0] md;
    wire          mv, ml;
    logic         mr = 1'b1;
    wire  [1:0]   cur_freq;
    wire          set_done;
    wire  [15:0]  set_cnt;
    wire          err_short, err_long;
    logic         err_clr = 1'b0;

    pmp_phase_sched #(.PHASE_NUM(8), .DATA_WIDTH(16), .PKT_LEN(PKT_LEN), .CNT_WIDTH(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axis_tdata(s_data[0]), .s0_axis_tvalid(s_valid[0]), .s0_axis_tready(s_ready[0]), .s0_axis_tlast(s_last[0]),
        .s1_axis_tdata(s_data[1]), .s1_axis_tvalid(s_valid[1]), .s1_axis_tready(s_ready[1]), .s1_axis_tlast(s_last[1]),
        .s2_axis_tdata(s_data[2]), .s2_axis_tvalid(s_valid[2]), .s2_axis_tready(s_ready[2]), .s2_axis_tlast(s_last[2]),
        .m_axis_tdata(md), .m_axis_tvalid(mv), .m_axis_tready(mr), .m_axis_tlast(ml),
        .cur_freq(cur_freq), .set_done(set_done), .set_cnt(set_cnt),
        .err_short(err_short), .err_long(err_long), .err_clr(err_clr)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [127:0] d;
        logic         last;
        logic         set_end;
    } beat_t;

    int checks = 0;
    int errors = 0;
    beat_t        exp_q[$];
    logic [128:0] src0_q[$], src1_q[$], src2_q[$];
    logic [2:0]   src_en = '0;
    int           vprob = 100;
    int           rmode = 0;      // 0: ready high, 1: toggle, 2: random
    int           exp_sets = 0;
    logic         ex_short = 1'b0, ex_long = 1'b0;
    int           fire_cnt = 0, done_cnt = 0, drain_cyc = 0, cur_run = 0, best_run = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            0: return src0_q.size();
            1: return src1_q.size();
            default: return src2_q.size();
        endcase
    endfunction

    function automatic logic [128:0] qfront(input int ch);
        case (ch)
            0: return src0_q[0];
            1: return src1_q[0];
            default: return src2_q[0];
        endcase
    endfunction

    task automatic qpop(input int ch);
        case (ch)
            0: void'(src0_q.pop_front());
            1: void'(src1_q.pop_front());
            default: void'(src2_q.pop_front());
        endcase
    endtask

    // Queue one packet on a source and append what downstream must see.
    task automatic add_pkt(input int ch, input int len, input logic cst, input logic [127:0] pat);
        int nf;
        logic [127:0] d;
        nf = len;
`ifdef PMP_SCHED_LEN_CHECK_EN
        if (len < PKT_LEN) ex_short = 1'b1;
        if (len > PKT_LEN) begin ex_long = 1'b1; nf = PKT_LEN; end
`endif
        for (int k = 0; k < len; k++) begin
            d = cst ? pat : {$urandom(), $urandom(), $urandom(), $urandom()};
            case (ch)
                0: src0_q.push_back({k == len - 1, d});
                1: src1_q.push_back({k == len - 1, d});
                default: src2_q.push_back({k == len - 1, d});
            endcase
            if (k < nf) exp_q.push_back('{d: d, last: (k == nf - 1), set_end: (ch == 2)});
        end
        if (ch == 2) exp_sets++;
    endtask

    function automatic int rlen();
`ifdef PMP_SCHED_LEN_CHECK_EN
        return ($urandom_range(99) < 80) ? PKT_LEN : int'($urandom_range(PKT_LEN + 12, 2));
`else
        return int'($urandom_range(24, 2));
`endif
    endfunction

    task automatic add_set_rand();
        for (int c = 0; c < 3; c++) add_pkt(c, rlen(), 1'b0, '0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || qsize(0) != 0 || qsize(1) != 0 || qsize(2) != 0) && n < budget) begin
            @(posedge aclk);
            n++;
        end
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("idle_within_budget", n < budget, 1'b1);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_set_cnt"}, set_cnt, 16'(exp_sets));
        chk({tag, "_err_short"}, err_short, ex_short);
        chk({tag, "_err_long"}, err_long, ex_long);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tvalid"}, mv, 1'b0);
        chk({tag, "_tlast"}, ml, 1'b0);
        chk({tag, "_tdata"}, md, '0);
        chk({tag, "_tready"}, s_ready, 3'b000);
        chk({tag, "_cur_freq"}, cur_freq, 2'd0);
        chk({tag, "_set_done"}, set_done, 1'b0);
        chk({tag, "_set_cnt"}, set_cnt, 16'd0);
        chk({tag, "_err_short"}, err_short, 1'b0);
        chk({tag, "_err_long"}, err_long, 1'b0);
    endtask

    // Source drivers and downstream ready generator.
    logic [2:0]   fire_s;
    logic [128:0] fv;
    always begin
        @(negedge aclk);
        fire_s = s_valid & s_ready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (fire_s[i] && qsize(i) > 0) qpop(i);
            if (src_en[i] && qsize(i) > 0 &&
                ((s_valid[i] && !fire_s[i]) || $urandom_range(99) < vprob)) begin
                fv = qfront(i);
                s_valid[i] = 1'b1;
                s_data[i]  = fv[127:0];
                s_last[i]  = fv[128];
            end else begin
                s_valid[i] = 1'b0;
            end
        end
        case (rmode)
            0: mr = 1'b1;
            1: mr = ~mr;
            default: mr = ($urandom_range(99) < 60);
        endcase
    end

    // Output monitor: scoreboard compare, stall stability, backpressure.
    logic         prev_stall = 1'b0, prev_l;
    logic [127:0] prev_d;
    beat_t        e;
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
            cur_run = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", mv, 1'b1);
                chk("stall_data", md, prev_d);
                chk("stall_last", ml, prev_l);
            end
            if (mv && !mr && cur_freq != 2'd3) chk("backpressure_tready", s_ready, 3'b000);
            if (cur_freq == 2'd3) drain_cyc++;
            if (set_done) done_cnt++;
            if (mv && mr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", md, e.d);
                    chk("beat_last", ml, e.last);
                    chk("set_done_on_beat", set_done, e.last && e.set_end);
                end
                fire_cnt++;
                cur_run++;
                if (cur_run > best_run) best_run = cur_run;
            end else begin
                cur_run = 0;
                chk("set_done_idle", set_done, 1'b0);
            end
            prev_stall = mv && !mr;
            prev_d = md;
            prev_l = ml;
        end
    end

    int fb, db, dcb, n;
    initial begin
        s_data[0] = '0; s_data[1] = '0; s_data[2] = '0;

        // Reset state and tready rise.
        repeat (3) @(negedge aclk);
        chk_reset_vals("reset");
        @(posedge aclk); #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("tready_before_edge", s_ready, 3'b000);
        @(negedge aclk);
        chk("tready_rise", s_ready, 3'b001);

        // Constant-pattern set; sources become valid low -> high.
        fb = fire_cnt; db = done_cnt;
        add_pkt(0, 256, 1'b1, {8{16'h53A1}});
        add_pkt(1, 256, 1'b1, {8{16'h2249}});
        add_pkt(2, 256, 1'b1, {8{16'h432A}});
        src_en[2] = 1'b1; repeat (10) @(negedge aclk);
        src_en[1] = 1'b1; repeat (10) @(negedge aclk);
        chk("t1_no_early_output", fire_cnt - fb, 0);
        chk("t1_cur_freq_wait", cur_freq, 2'd0);
        src_en[0] = 1'b1;
        wait_idle(20000);
        chk("t1_beats", fire_cnt - fb, 768);
        chk("t1_set_done_pulses", done_cnt - db, 1);
        chk("t1_set_cnt", set_cnt, 16'd1);
        chk_status("t1");

        // Four back-to-back sets under continuous ready.
        fb = fire_cnt;
        for (int s = 0; s < 4; s++) for (int c = 0; c < 3; c++) add_pkt(c, 256, 1'b0, '0);
        wait_idle(20000);
        chk("t2_beats", fire_cnt - fb, 3072);
        chk("t2_no_gaps", best_run >= 3072, 1'b1);
        chk_status("t2");

        // Ready toggling across channel switches.
        rmode = 1;
        for (int s = 0; s < 2; s++) add_set_rand();
        wait_idle(20000);
        chk_status("t3");

        // Random valid and ready.
        rmode = 2; vprob = 60;
        for (int s = 0; s < 3; s++) add_set_rand();
        wait_idle(40000);
        chk_status("t4");
        rmode = 0; vprob = 100;

`ifdef PMP_SCHED_LEN_CHECK_EN
        @(posedge aclk); #1 err_clr = 1'b1;
        @(posedge aclk); #1 err_clr = 1'b0;
        ex_short = 1'b0; ex_long = 1'b0;
        @(negedge aclk);
        chk("clr_err_short", err_short, 1'b0);
        chk("clr_err_long", err_long, 1'b0);

        // Short mid-frequency packet.
        fb = fire_cnt;
        add_pkt(0, 256, 1'b0, '0);
        add_pkt(1, 200, 1'b0, '0);
        add_pkt(2, 256, 1'b0, '0);
        wait_idle(20000);
        chk("short_beats", fire_cnt - fb, 712);
        chk_status("short");
        @(posedge aclk); #1 err_clr = 1'b1;
        @(posedge aclk); #1 err_clr = 1'b0;
        ex_short = 1'b0;
        @(negedge aclk);
        chk("short_cleared", err_short, 1'b0);

        // Long high-frequency packet, drained.
        fb = fire_cnt; dcb = drain_cyc;
        add_pkt(0, 300, 1'b0, '0);
        wait_idle(20000);
        chk("long_beats", fire_cnt - fb, 256);
        chk("long_drain_seen", drain_cyc - dcb >= 44, 1'b1);
        chk("long_cur_freq_after", cur_freq, 2'd1);
        chk("long_err_long", err_long, 1'b1);
        add_pkt(1, 256, 1'b0, '0);
        add_pkt(2, 256, 1'b0, '0);
        wait_idle(20000);
        chk_status("long");
`endif

        // Reset in the middle of the mid-frequency packet.
        fb = fire_cnt;
        for (int c = 0; c < 3; c++) add_pkt(c, 256, 1'b0, '0);
        n = 0;
        while (fire_cnt - fb < 356 && n < 5000) begin @(negedge aclk); n++; end
        chk("rst_reach_beat", n < 5000, 1'b1);
        chk("rst_in_mid_channel", cur_freq, 2'd1);
        @(posedge aclk); #2 aresetn = 1'b0;
        #1;
        src_en = '0;
        src0_q.delete(); src1_q.delete(); src2_q.delete(); exp_q.delete();
        exp_sets = 0; ex_short = 1'b0; ex_long = 1'b0;
        chk_reset_vals("mid_reset");
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        fb = fire_cnt;
        add_set_rand();
        src_en = 3'b110;
        repeat (8) @(negedge aclk);
        chk("post_rst_wait_s0", fire_cnt - fb, 0);
        chk("post_rst_cur_freq", cur_freq, 2'd0);
        src_en = 3'b111;
        wait_idle(20000);
        chk_status("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pmp_phase_sched.md
# pmp_phase_sched

Three-way packet scheduler in front of `cal_abs_phase` in the PMP role. Three wrapped-phase producers (high, mid, low fringe frequency) each deliver AXI-Stream packets on their own slave port. This block merges them onto the single master stream in the strict order high → mid → low, one whole packet at a time, so downstream always receives a complete three-packet set. It counts completed sets and, optionally, enforces a fixed packet length.

## Interface
Parameters:
- `PHASE_NUM`, 8, phase lanes per beat.
- `DATA_WIDTH`, 16, bits per lane; bus width is W = `PHASE_NUM*DATA_WIDTH`.
- `PKT_LEN`, 256, expected beats per packet; legal range ≥2.
- `CNT_WIDTH`, 16, width of the set counter.

Ports:
- `aclk`, in, 1, clock.
- `aresetn`, in, 1, reset, asynchronous, active-low.
- `s0_axis_tdata`/`s1_axis_tdata`/`s2_axis_tdata`, in, W each, phase data for high/mid/low frequency.
- `s0_axis_tvalid`/`s1_`/`s2_`, in, 1 each, source valid.
- `s0_axis_tready`/`s1_`/`s2_`, out, 1 each, source ready.
- `s0_axis_tlast`/`s1_`/`s2_`, in, 1 each, end of packet.
- `m_axis_tdata`, out, W, merged data.
- `m_axis_tvalid`, out, 1, output valid.
- `m_axis_tready`, in, 1, downstream ready.
- `m_axis_tlast`, out, 1, end of packet.
- `cur_freq`, out, 2, channel currently granted: 0/1/2; 3 while draining.
- `set_done`, out, 1, one-cycle pulse when the low-frequency packet's last beat is accepted downstream.
- `set_cnt`, out, CNT_WIDTH, number of completed sets; wraps modulo 2^CNT_WIDTH.
- `err_short`, `err_long`, out, 1 each, sticky length errors.
- `err_clr`, in, 1, synchronous clear of both sticky errors.

## Operation
State machine:
- `F0`: only s0 may transfer.
- `F1`: only s1 may transfer.
- `F2`: only s2 may transfer.
- `DRAIN`: discards surplus beats. Present only with the macro.

Transitions:
- An input beat is accepted on `sN_tvalid && sN_tready` for the granted channel N.
- The state advances on acceptance of that channel's packet-closing beat: F0→F1→F2→F0.
- Non-granted channels hold `tready`=0 and are never consumed.

Output register slice:
- One register stage carries tdata, tvalid and tlast.
- Granted `sN_tready` = `!m_axis_tvalid || m_axis_tready`. This sustains one beat per cycle under continuous ready.
- Output data is unchanged, lane for lane.

Counters and status:
- `set_cnt` increments when the output beat with tlast=1 from F2 is accepted downstream. `set_done` pulses in the same cycle.
- `cur_freq` reflects the state register.
- Errors are sticky. `err_clr` clears them. A set in the same cycle as `err_clr` wins.

Reset:
- Asserting `aresetn` at any time, including mid-packet, returns the block to F0 with the beat counter at 0.
- Any partial set is abandoned; the source is responsible for flushing.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, all `sN_tready`=0, `cur_freq`=0, `set_done`=0, `set_cnt`=0, `err_short`=0, `err_long`=0.
- `tready` rises in the first cycle after reset deasserts.
- Latency: 1 cycle from input acceptance to `m_axis_tvalid`.
- Throughput: 1 beat/cycle, including across channel switches; there are no bubbles between packets.
- Backpressure: while `m_axis_tvalid && !m_axis_tready`, the output holds stable and all `sN_tready`=0.
- Channel switch: the first beat of the next channel may be accepted in the cycle after the closing beat is accepted.

## Configuration
The feature is controlled by `PMP_SCHED_LEN_CHECK_EN`.

Defined:
- A beat counter counts accepted beats in 0..`PKT_LEN`-1.
- Input tlast while the counter is below `PKT_LEN`-1: forward with tlast=1, set `err_short`, advance state.
- Counter at `PKT_LEN`-1 with input tlast=0: force output tlast=1, set `err_long`, enter `DRAIN`.
- `DRAIN`:
  - `tready`=1 on the offending channel; beats are discarded, nothing is output.
  - On that channel's tlast, go to the next F state.
  - `cur_freq`=3 while in `DRAIN`.

Undefined:
- Packets close on input tlast only; there is no counter and no `DRAIN` state.
- `err_short` and `err_long` are tied to 0.

## Test plan
- Each channel sends one 256-beat packet of {8{16'h53A1}}/{8{16'h2249}}/{8{16'h432A}}; s2 is valid first, s0 last → output is 768 beats ordered 53A1, 2249, 432A; tlast on beats 256/512/768; `set_cnt`=1; one `set_done`.
- Continuous ready and all sources valid, 4 sets → 3072 beats with no gap cycles; `set_cnt`=4.
- `m_axis_tready` toggling 1-0 during a channel switch → no beat lost or duplicated; output stable while stalled.
- (EN) s1 packet ends at beat 200 → 200 beats forwarded; `err_short`=1; s2 is granted next; `err_clr` returns it to 0.
- (EN) s0 packet of 300 beats → 256 forwarded with tlast on beat 256; `err_long`=1; 44 beats drained; `cur_freq`=3 during the drain, then 1.
- `aresetn` pulsed at beat 100 of s1 → all outputs at reset values; next accepted beat comes from s0.
